// File: rtl/response_writeback_pkg.sv
// response_writeback_pkg: shared widths, response-word layout, opcodes and FSM states
// for the response writeback block.
package response_writeback_pkg;
   localparam int RESP_W = 45;
   localparam int DATA_W = 32;
   localparam int RD_W   = 5;
   localparam int SRC_W  = 4;
   localparam int CNT_W  = 4;

   localparam logic [1:0] ACK      = 2'b00;
   localparam logic [1:0] ACK_DATA = 2'b01;

   typedef enum logic [1:0] {IDLE, WAIT, CAPTURE, COMMIT} state_t;

   // Field order mirrors the FIFO word, MSB first: op[44:43] src[42:39] rd[38:34] data[33:2] denied[1] rsvd[0]
   typedef struct packed {
      logic [1:0]        op;
      logic [SRC_W-1:0]  src;
      logic [RD_W-1:0]   rd;
      logic [DATA_W-1:0] data;
      logic              denied;
      logic              rsvd;
   } resp_t;
endpackage

// File: rtl/response_writeback_if.sv
// response_writeback_if: response-FIFO read port and register-file write port.
interface response_writeback_if;
   import response_writeback_pkg::*;
   logic              response_fifo_empty_signal;
   logic [RESP_W-1:0] read_data_response_fifo;
   logic              read_response_fifo_signal;
   logic              rf_write_ready;
   logic              rf_we;
   logic [RD_W-1:0]   rf_waddr;
   logic [DATA_W-1:0] rf_wdata;
   modport master (
      input  response_fifo_empty_signal, read_data_response_fifo, rf_write_ready,
      output read_response_fifo_signal, rf_we, rf_waddr, rf_wdata
   );
   modport slave (
      output response_fifo_empty_signal, read_data_response_fifo, rf_write_ready,
      input  read_response_fifo_signal, rf_we, rf_waddr, rf_wdata
   );
endinterface

// File: rtl/response_writeback_outstanding_counter.sv
// outstanding_counter: saturating up/down counter; err flags an increment at max or decrement at 0.
module outstanding_counter #(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         inc,
   input  logic         dec,
   output logic [W-1:0] count,
   output logic         err
);
   logic up, dn;
   assign up  = inc & ~dec;
   assign dn  = dec & ~inc;
   assign err = (up && &count) || (dn && count == '0);
   always_ff @(posedge clk or negedge reset)
      if (!reset) count <= '0;
      else if (up && !(&count)) count <= count + 1'b1;
      else if (dn && count != '0) count <= count - 1'b1;
endmodule

// File: rtl/response_writeback.sv
// response_writeback: drains the response FIFO, retires loads to the register file and
// stores as acks, and tracks outstanding load/store counts.
module response_writeback
   import response_writeback_pkg::*;
(
   input  logic               clk,
   input  logic               reset,
   response_writeback_if.master bus,
   input  logic               load_issue,
   input  logic               store_issue,
   output logic               store_ack,
   output logic [SRC_W-1:0]   ack_source,
   output logic [CNT_W-1:0]   load_outstanding,
   output logic [CNT_W-1:0]   store_outstanding,
   output logic               resp_error,
   output logic               busy
);
   state_t           state, next;
   resp_t            hold;
   logic [SRC_W-1:0] src_q;
   logic             is_load, is_store, wr, ld_dec, st_dec, ld_err, st_err, err_set;
   always_ff @(posedge clk or negedge reset)
      if (!reset) state <= IDLE;
      else state <= next;
   always_ff @(posedge clk or negedge reset)
      if (!reset) hold <= '0;
      else if (state == CAPTURE) hold <= bus.read_data_response_fifo;
   assign is_load  = state == COMMIT && hold.op == ACK_DATA;
   assign is_store = state == COMMIT && hold.op == ACK;
   assign wr       = is_load && !hold.denied && hold.rd != '0;
   // Only a real register write waits on rf_write_ready; every other retire takes one cycle.
   assign ld_dec   = is_load && (!wr || bus.rf_write_ready);
   assign st_dec   = is_store;
   assign err_set  = (state == COMMIT && (hold.denied || hold.op[1])) || ld_err || st_err;
   always_comb begin
      next = state;
      case (state)
         IDLE:    next = bus.response_fifo_empty_signal ? IDLE : WAIT;
         WAIT:    next = CAPTURE;
         CAPTURE: next = COMMIT;
         COMMIT:  next = (wr && !bus.rf_write_ready) ? COMMIT : IDLE;
         default: next = IDLE;
      endcase
   end
   assign bus.read_response_fifo_signal = reset && state == IDLE && !bus.response_fifo_empty_signal;
   assign bus.rf_we    = wr;
   assign bus.rf_waddr = hold.rd;
   assign bus.rf_wdata = hold.data;
   assign store_ack    = is_store && !hold.denied;
   assign ack_source   = (wr || store_ack) ? hold.src : src_q;
   assign busy         = state != IDLE || load_outstanding != '0 || store_outstanding != '0;
   always_ff @(posedge clk or negedge reset)
      if (!reset) src_q <= '0;
      else src_q <= ack_source;
   always_ff @(posedge clk or negedge reset)
      if (!reset) resp_error <= 1'b0;
      else if (err_set) resp_error <= 1'b1;
   outstanding_counter #(.W(CNT_W)) u_load_cnt (
      .clk(clk), .reset(reset), .inc(load_issue), .dec(ld_dec),
      .count(load_outstanding), .err(ld_err)
   );
   outstanding_counter #(.W(CNT_W)) u_store_cnt (
      .clk(clk), .reset(reset), .inc(store_issue), .dec(st_dec),
      .count(store_outstanding), .err(st_err)
   );
endmodule

// File: tb/tb_response_writeback.sv
// tb_response_writeback: directed and randomized checks of response_writeback against a
// FIFO model and an event-level scoreboard.
module tb_response_writeback;
   import response_writeback_pkg::*;
   logic clk = 0, reset = 0, load_issue = 0, store_issue = 0;
   logic store_ack, resp_error, busy;
   logic [SRC_W-1:0] ack_source;
   logic [CNT_W-1:0] load_outstanding, store_outstanding;
   int n_tests = 0, n_fail = 0;
   logic [RESP_W-1:0] fifo_mem [0:255];
   int wp = 0, rp = 0;

   response_writeback_if bus();
   response_writeback dut (
      .clk(clk), .reset(reset), .bus(bus), .load_issue(load_issue), .store_issue(store_issue),
      .store_ack(store_ack), .ack_source(ack_source), .load_outstanding(load_outstanding),
      .store_outstanding(store_outstanding), .resp_error(resp_error), .busy(busy)
   );

   always #5 clk = ~clk;
   assign bus.response_fifo_empty_signal = (wp == rp);
   always @(posedge clk)
      if (bus.read_response_fifo_signal && wp != rp) begin
         bus.read_data_response_fifo <= fifo_mem[rp[7:0]];
         rp <= rp + 1;
      end

   function automatic logic [RESP_W-1:0] mk(logic [1:0] op, logic [3:0] src, logic [4:0] rd,
                                             logic [31:0] d, logic den);
      return {op, src, rd, d, den, 1'b0};
   endfunction

   task automatic push(input logic [RESP_W-1:0] w);
      fifo_mem[wp[7:0]] = w;
      wp = wp + 1;
   endtask

   task automatic do_reset();
      @(negedge clk); reset = 0; load_issue = 0; store_issue = 0;
      @(negedge clk); reset = 1;
   endtask

   task automatic drain(input int n, output int we_cnt, output int ack_cnt);
      we_cnt = 0; ack_cnt = 0;
      for (int c = 0; c < n; c++) begin
         @(negedge clk); #1;
         if (bus.rf_we) we_cnt++;
         if (store_ack) ack_cnt++;
      end
   endtask

   task automatic test_reset();
      logic [53:0] obs;
      reset = 0;
      repeat (3) @(negedge clk);
      #1;
      obs = {bus.read_response_fifo_signal, bus.rf_we, bus.rf_waddr, bus.rf_wdata, store_ack,
             ack_source, load_outstanding, store_outstanding, resp_error, busy};
      n_tests++;
      if (obs !== '0) begin n_fail++; $display("FAIL reset_outputs got %h want 0", obs); end
      @(negedge clk); reset = 1; #1;
      n_tests++;
      if ({busy, bus.read_response_fifo_signal} !== 2'b00) begin
         n_fail++; $display("FAIL reset_release busy/read got %b want 00", {busy, bus.read_response_fifo_signal});
      end
   endtask

   task automatic test_single_load();
      bus.rf_write_ready = 1;
      @(negedge clk); load_issue = 1;
      @(negedge clk); load_issue = 0; push(mk(ACK_DATA, 4'd5, 5'd7, 32'h14, 1'b0)); #1;
      n_tests++;
      if (load_outstanding !== 4'd1) begin n_fail++; $display("FAIL load_issue_cnt got %0d want 1", load_outstanding); end
      n_tests++;
      if (bus.read_response_fifo_signal !== 1'b1) begin n_fail++; $display("FAIL load_read_pulse got 0 want 1"); end
      for (int c = 0; c < 2; c++) begin
         @(negedge clk); #1;
         n_tests++;
         if ({bus.read_response_fifo_signal, bus.rf_we} !== 2'b00) begin
            n_fail++; $display("FAIL load_gap read/we got %b want 00", {bus.read_response_fifo_signal, bus.rf_we});
         end
      end
      @(negedge clk); #1;
      n_tests++;
      if ({bus.rf_we, bus.rf_waddr, bus.rf_wdata, ack_source} !== {1'b1, 5'd7, 32'd20, 4'd5}) begin
         n_fail++; $display("FAIL load_write got we=%b a=%0d d=%0d s=%0d want 1/7/20/5",
                            bus.rf_we, bus.rf_waddr, bus.rf_wdata, ack_source);
      end
      @(negedge clk); #1;
      n_tests++;
      if ({load_outstanding, bus.rf_we, busy} !== {4'd0, 1'b0, 1'b0}) begin
         n_fail++; $display("FAIL load_retire got cnt=%0d we=%b busy=%b want 0/0/0", load_outstanding, bus.rf_we, busy);
      end
   endtask

   task automatic test_store();
      int acks = 0, we = 0;
      logic [3:0] last_src = 4'hx;
      bus.rf_write_ready = 0;
      @(negedge clk); store_issue = 1;
      @(negedge clk); store_issue = 0; push(mk(ACK, 4'd3, 5'd9, $urandom, 1'b0)); #1;
      n_tests++;
      if (store_outstanding !== 4'd1) begin n_fail++; $display("FAIL store_issue_cnt got %0d want 1", store_outstanding); end
      for (int c = 0; c < 8; c++) begin
         if (store_ack) begin acks++; last_src = ack_source; end
         if (bus.rf_we) we++;
         @(negedge clk); #1;
      end
      n_tests++;
      if ({acks, we} !== {32'd1, 32'd0}) begin n_fail++; $display("FAIL store_ack_count got ack=%0d we=%0d want 1/0", acks, we); end
      n_tests++;
      if (last_src !== 4'd3) begin n_fail++; $display("FAIL store_ack_source got %0d want 3", last_src); end
      n_tests++;
      if ({store_outstanding, ack_source} !== {4'd0, 4'd3}) begin
         n_fail++; $display("FAIL store_retire got cnt=%0d src=%0d want 0/3", store_outstanding, ack_source);
      end
   endtask

   task automatic test_stall();
      int t = 0, rp0;
      logic [31:0] d = $urandom;
      bus.rf_write_ready = 0;
      @(negedge clk); load_issue = 1;
      @(negedge clk); load_issue = 0; push(mk(ACK_DATA, 4'd1, 5'd12, d, 1'b0));
      do begin @(negedge clk); #1; t++; end while (!bus.rf_we && t < 10);
      n_tests++;
      if (bus.rf_we !== 1'b1) begin n_fail++; $display("FAIL stall_wait got we=0 want 1 within 10 cycles"); end
      rp0 = rp;
      for (int k = 1; k < 5; k++) begin
         @(negedge clk); #1;
         n_tests++;
         if ({bus.rf_we, bus.rf_waddr, bus.rf_wdata, load_outstanding} !== {1'b1, 5'd12, d, 4'd1}) begin
            n_fail++; $display("FAIL stall_hold got we=%b a=%0d d=%h cnt=%0d want 1/12/%h/1",
                               bus.rf_we, bus.rf_waddr, bus.rf_wdata, load_outstanding, d);
         end
      end
      @(negedge clk); bus.rf_write_ready = 1; #1;
      n_tests++;
      if (bus.rf_we !== 1'b1) begin n_fail++; $display("FAIL stall_accept got we=0 want 1"); end
      @(negedge clk); #1;
      n_tests++;
      if ({bus.rf_we, load_outstanding, rp} !== {1'b0, 4'd0, rp0}) begin
         n_fail++; $display("FAIL stall_retire got we=%b cnt=%0d reads=%0d want 0/0/%0d", bus.rf_we, load_outstanding, rp, rp0);
      end
   endtask

   task automatic test_back_to_back();
      int rd_cyc[$];
      logic [36:0] wr_q[$], exp_q[$];
      bus.rf_write_ready = 1;
      @(negedge clk); load_issue = 1;
      repeat (2) @(negedge clk);
      @(negedge clk); load_issue = 0;
      for (int i = 1; i <= 3; i++) begin
         logic [31:0] d = $urandom;
         push(mk(ACK_DATA, 4'(i), 5'(i), d, 1'b0));
         exp_q.push_back({5'(i), d});
      end
      for (int c = 0; c < 16; c++) begin
         if (c > 0) @(negedge clk);
         #1;
         if (bus.read_response_fifo_signal) rd_cyc.push_back(c);
         if (bus.rf_we && bus.rf_write_ready) wr_q.push_back({bus.rf_waddr, bus.rf_wdata});
      end
      n_tests++;
      if (rd_cyc.size() != 3) begin n_fail++; $display("FAIL b2b_read_count got %0d want 3", rd_cyc.size()); end
      else begin
         n_tests++;
         if (rd_cyc[1] - rd_cyc[0] != 4 || rd_cyc[2] - rd_cyc[1] != 4) begin
            n_fail++; $display("FAIL b2b_read_spacing got %0d,%0d,%0d want 4 apart", rd_cyc[0], rd_cyc[1], rd_cyc[2]);
         end
      end
      n_tests++;
      if (wr_q.size() != 3) begin n_fail++; $display("FAIL b2b_write_count got %0d want 3", wr_q.size()); end
      else for (int i = 0; i < 3; i++) begin
         n_tests++;
         if (wr_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL b2b_write_%0d got %h want %h", i, wr_q[i], exp_q[i]); end
      end
      n_tests++;
      if (load_outstanding !== 4'd0) begin n_fail++; $display("FAIL b2b_cnt got %0d want 0", load_outstanding); end
   endtask

   task automatic test_random();
      int n_ld = 0, n_st = 0, t = 0;
      logic [RESP_W-1:0] words[$];
      logic [41:0] exp_q[$], obs;
      for (int i = 0; i < 12; i++) begin
         logic [1:0]  op  = 2'($urandom_range(0, 1));
         logic [3:0]  src = 4'($urandom_range(0, 15));
         logic [4:0]  rd  = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
         logic [31:0] d   = $urandom;
         words.push_back(mk(op, src, rd, d, 1'b0));
         if (op == ACK_DATA) begin
            n_ld++;
            if (rd != 0) exp_q.push_back({1'b1, src, rd, d});
         end else begin
            n_st++;
            exp_q.push_back({1'b0, src, 5'd0, 32'd0});
         end
      end
      for (int i = 0; i < 12; i++) begin
         @(negedge clk); load_issue = (i < n_ld); store_issue = (i < n_st);
      end
      @(negedge clk); load_issue = 0; store_issue = 0; #1;
      n_tests++;
      if ({load_outstanding, store_outstanding} !== {4'(n_ld), 4'(n_st)}) begin
         n_fail++; $display("FAIL rand_issue got %0d/%0d want %0d/%0d", load_outstanding, store_outstanding, n_ld, n_st);
      end
      foreach (words[i]) push(words[i]);
      while ((exp_q.size() > 0 || busy) && t < 400) begin
         @(negedge clk); bus.rf_write_ready = 1'($urandom_range(0, 1)); #1; t++;
         if ((bus.rf_we && bus.rf_write_ready) || store_ack) begin
            obs = bus.rf_we ? {1'b1, ack_source, bus.rf_waddr, bus.rf_wdata} : {1'b0, ack_source, 5'd0, 32'd0};
            n_tests++;
            if (exp_q.size() == 0) begin n_fail++; $display("FAIL rand_unexpected got %h want nothing", obs); end
            else if (obs !== exp_q[0]) begin n_fail++; $display("FAIL rand_event got %h want %h", obs, exp_q.pop_front()); end
            else void'(exp_q.pop_front());
         end
      end
      n_tests++;
      if (exp_q.size() != 0 || busy) begin n_fail++; $display("FAIL rand_timeout got %0d pending busy=%b want 0/0", exp_q.size(), busy); end
      n_tests++;
      if ({load_outstanding, store_outstanding, resp_error} !== 9'd0) begin
         n_fail++; $display("FAIL rand_final got %0d/%0d err=%b want 0/0/0", load_outstanding, store_outstanding, resp_error);
      end
      bus.rf_write_ready = 1;
   endtask

   task automatic test_simultaneous();
      int t = 0, we, acks;
      bus.rf_write_ready = 1;
      @(negedge clk); load_issue = 1;
      @(negedge clk); load_issue = 0; push(mk(ACK_DATA, 4'd2, 5'd2, $urandom, 1'b0));
      do begin @(negedge clk); #1; t++; end while (!bus.rf_we && t < 10);
      load_issue = 1;
      @(negedge clk); load_issue = 0; #1;
      n_tests++;
      if ({load_outstanding, resp_error} !== {4'd1, 1'b0}) begin
         n_fail++; $display("FAIL simul_inc_dec got cnt=%0d err=%b want 1/0", load_outstanding, resp_error);
      end
      push(mk(ACK_DATA, 4'd6, 5'd0, $urandom, 1'b0));
      drain(6, we, acks);
      n_tests++;
      if ({we, load_outstanding} !== {32'd0, 4'd0}) begin
         n_fail++; $display("FAIL rd0_suppress got we=%0d cnt=%0d want 0/0", we, load_outstanding);
      end
   endtask

   task automatic test_errors();
      int we, acks;
      bus.rf_write_ready = 1;
      do_reset();
      @(negedge clk); load_issue = 1;
      @(negedge clk); load_issue = 0; push(mk(ACK_DATA, 4'd1, 5'd4, $urandom, 1'b1));
      drain(6, we, acks);
      n_tests++;
      if ({we, load_outstanding, resp_error} !== {32'd0, 4'd0, 1'b1}) begin
         n_fail++; $display("FAIL err_denied got we=%0d cnt=%0d err=%b want 0/0/1", we, load_outstanding, resp_error);
      end
      do_reset(); #1;
      n_tests++;
      if (resp_error !== 1'b0) begin n_fail++; $display("FAIL err_clear got 1 want 0"); end
      @(negedge clk); store_issue = 1;
      @(negedge clk); store_issue = 0; push(mk(2'b10, 4'd2, 5'd3, $urandom, 1'b0));
      drain(6, we, acks);
      n_tests++;
      if ({we, acks, store_outstanding, load_outstanding, resp_error} !== {32'd0, 32'd0, 4'd1, 4'd0, 1'b1}) begin
         n_fail++; $display("FAIL err_illegal got we=%0d ack=%0d st=%0d ld=%0d err=%b want 0/0/1/0/1",
                            we, acks, store_outstanding, load_outstanding, resp_error);
      end
      do_reset();
      push(mk(ACK, 4'd7, 5'd0, 32'd0, 1'b0));
      drain(6, we, acks);
      n_tests++;
      if ({we, acks, store_outstanding, resp_error} !== {32'd0, 32'd1, 4'd0, 1'b1}) begin
         n_fail++; $display("FAIL err_underflow got we=%0d ack=%0d cnt=%0d err=%b want 0/1/0/1", we, acks, store_outstanding, resp_error);
      end
      @(negedge clk); load_issue = 1;
      @(negedge clk); load_issue = 0; push(mk(ACK_DATA, 4'd1, 5'd5, $urandom, 1'b0));
      drain(6, we, acks);
      n_tests++;
      if ({we, load_outstanding, resp_error} !== {32'd1, 4'd0, 1'b1}) begin
         n_fail++; $display("FAIL err_sticky got we=%0d cnt=%0d err=%b want 1/0/1", we, load_outstanding, resp_error);
      end
      do_reset();
      @(negedge clk); load_issue = 1;
      repeat (16) @(negedge clk);
      load_issue = 0; #1;
      n_tests++;
      if ({load_outstanding, resp_error} !== {4'd15, 1'b1}) begin
         n_fail++; $display("FAIL err_overflow got cnt=%0d err=%b want 15/1", load_outstanding, resp_error);
      end
   endtask

   task automatic test_reset_mid_commit();
      int t = 0;
      bus.rf_write_ready = 0;
      @(negedge clk); load_issue = 1;
      @(negedge clk); load_issue = 0; push(mk(ACK_DATA, 4'd9, 5'd9, $urandom, 1'b0));
      do begin @(negedge clk); #1; t++; end while (!bus.rf_we && t < 10);
      n_tests++;
      if (bus.rf_we !== 1'b1) begin n_fail++; $display("FAIL midrst_reach got we=0 want 1"); end
      #1 reset = 0; #1;
      n_tests++;
      if ({bus.rf_we, busy, load_outstanding, store_outstanding, resp_error, bus.rf_waddr} !== '0) begin
         n_fail++; $display("FAIL midrst_clear got we=%b busy=%b ld=%0d st=%0d err=%b a=%0d want all 0",
                            bus.rf_we, busy, load_outstanding, store_outstanding, resp_error, bus.rf_waddr);
      end
      @(negedge clk); reset = 1; bus.rf_write_ready = 1;
      repeat (3) @(negedge clk);
      #1;
      n_tests++;
      if ({bus.rf_we, busy, bus.read_response_fifo_signal} !== 3'b000) begin
         n_fail++; $display("FAIL midrst_idle got we=%b busy=%b read=%b want 000", bus.rf_we, busy, bus.read_response_fifo_signal);
      end
   endtask

   initial begin
      bus.rf_write_ready = 0;
      test_reset();
      test_single_load();
      test_store();
      test_stall();
      test_back_to_back();
      test_random();
      test_simultaneous();
      test_errors();
      test_reset_mid_commit();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
